// File: rtl/program_loader.sv
// Program loader: packs a host byte stream big-endian into 32-bit words,
// treats the first word of each image as a header (payload word count),
// raises a program request to the memory block on each header and buffers
// all words in a 2^FIFO_AW x 32 FIFO that the memory block drains.
//
// Handshakes: a byte moves when byte_valid and byte_ready are both 1 on a
// rising edge; program_o is a level held until program_ack is sampled high;
// program_buffer_read pops the head word into program_buffer_q on the same
// edge when the FIFO is non-empty.
//
// The program request port is named program_o because "program" is a
// reserved word. dbg_state_o (0 = HEADER, 1 = DATA) and dbg_count_o expose
// the FSM state and FIFO fill level for observation.
module program_loader #(
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [7:0]         byte_data,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               program_o,
   input  logic               program_ack,
   output logic               program_buffer_empty,
   output logic [31:0]        program_buffer_q,
   input  logic               program_buffer_read,
   output logic               busy,
   output logic               dbg_state_o,
   output logic [FIFO_AW:0]   dbg_count_o
);

   typedef enum logic {
      HEADER = 1'b0,
      DATA   = 1'b1
   } state_e;

   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

   state_e              state_q, state_d;
   logic [1:0]          lane_q, lane_d;
   logic [23:0]         shift_q, shift_d;
   logic [31:0]         words_rem_q, words_rem_d;
   logic                program_q, program_d;

   logic [FIFO_AW-1:0]  wptr_q, rptr_q;
   logic [FIFO_AW:0]    count_q;
   logic [31:0]         rdata_q;
   logic [31:0]         mem [DEPTH];

   logic                accept;
   logic                word_done;
   logic                rd_en;
   logic [31:0]         word;

   // Header bytes are held off while a previous request is still unacknowledged.
   assign byte_ready = (count_q != FULL_CNT) && !((state_q == HEADER) && program_q);
   assign accept     = byte_valid && byte_ready;
   assign word_done  = accept && (lane_q == 2'd3);
   assign word       = {shift_q, byte_data};
   assign rd_en      = program_buffer_read && (count_q != '0);

   assign program_o            = program_q;
   assign program_buffer_empty = (count_q == '0);
   assign program_buffer_q     = rdata_q;
   assign busy                 = (state_q == DATA) || program_q || (lane_q != 2'd0);
   assign dbg_state_o          = state_q;
   assign dbg_count_o          = count_q;

   // Byte lane counter and shift register for the first three bytes of a word.
   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      if (accept) begin
         lane_d  = lane_q + 2'd1;
         shift_d = {shift_q[15:0], byte_data};
      end
   end

   // Header/data FSM, remaining-word counter and program request level.
   always_comb begin
      state_d     = state_q;
      words_rem_d = words_rem_q;
      program_d   = program_q;
      if (program_q && program_ack) begin
         program_d = 1'b0;
      end
      if (word_done) begin
         case (state_q)
            HEADER: begin
               program_d   = 1'b1;
               words_rem_d = word;
               state_d     = (word != 32'd0) ? DATA : HEADER;
            end
            DATA: begin
               words_rem_d = words_rem_q - 32'd1;
               if (words_rem_q == 32'd1) begin
                  state_d = HEADER;
               end
            end
            default: state_d = HEADER;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= HEADER;
         lane_q      <= 2'd0;
         shift_q     <= 24'd0;
         words_rem_q <= 32'd0;
         program_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         shift_q     <= shift_d;
         words_rem_q <= words_rem_d;
         program_q   <= program_d;
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (word_done) begin
         mem[wptr_q] <= word;
      end
   end

   // FIFO pointers, fill count and registered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rdata_q <= 32'd0;
      end else begin
         if (word_done) begin
            wptr_q <= wptr_q + FIFO_AW'(1);
         end
         if (rd_en) begin
            rptr_q  <= rptr_q + FIFO_AW'(1);
            rdata_q <= mem[rptr_q];
         end
         case ({word_done, rd_en})
            2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed scenarios followed by randomized image
// streams, all checked every cycle against a queue-based reference model.
module tb_program_loader;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk;
   logic          reset_n;
   logic [7:0]    byte_data;
   logic          byte_valid;
   logic          byte_ready;
   logic          program_o;
   logic          program_ack;
   logic          program_buffer_empty;
   logic [31:0]   program_buffer_q;
   logic          program_buffer_read;
   logic          busy;
   logic          dbg_state_o;
   logic [AW:0]   dbg_count_o;

   int checks = 0;
   int errors = 0;

   // reference model
   logic [31:0] exp_q[$];
   logic [7:0]  m_bytes[$];
   bit          m_header;
   logic [31:0] m_rem;
   bit          m_prog;
   logic [31:0] m_q;
   bit          m_acc;
   bit          auto_ack;

   program_loader #(.FIFO_AW(AW)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .byte_data            (byte_data),
      .byte_valid           (byte_valid),
      .byte_ready           (byte_ready),
      .program_o            (program_o),
      .program_ack          (program_ack),
      .program_buffer_empty (program_buffer_empty),
      .program_buffer_q     (program_buffer_q),
      .program_buffer_read  (program_buffer_read),
      .busy                 (busy),
      .dbg_state_o          (dbg_state_o),
      .dbg_count_o          (dbg_count_o)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return (exp_q.size() < DEPTH) && !(m_header && m_prog);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_bytes.delete();
      m_header = 1'b1;
      m_rem    = 32'd0;
      m_prog   = 1'b0;
      m_q      = 32'd0;
      m_acc    = 1'b0;
   endtask

   // One rising edge of the reference behaviour.
   task automatic model_edge(input bit v, input logic [7:0] d, input bit rd, input bit ak);
      bit          np;
      logic [31:0] w;
      m_acc = v && m_ready();
      np    = m_prog;
      if (m_prog && ak) np = 1'b0;
      if (rd && exp_q.size() > 0) m_q = exp_q.pop_front();
      if (m_acc) begin
         m_bytes.push_back(d);
         if (m_bytes.size() == 4) begin
            w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            exp_q.push_back(w);
            if (m_header) begin
               np       = 1'b1;
               m_rem    = w;
               m_header = (w == 32'd0);
            end else begin
               m_rem = m_rem - 32'd1;
               if (m_rem == 32'd0) m_header = 1'b1;
            end
         end
      end
      m_prog = np;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ready"}, 32'(byte_ready), 32'(m_ready()));
      chk({tag, ".program"}, 32'(program_o), 32'(m_prog));
      chk({tag, ".empty"}, 32'(program_buffer_empty), 32'(exp_q.size() == 0));
      chk({tag, ".q"}, program_buffer_q, m_q);
      chk({tag, ".busy"}, 32'(busy), 32'(!m_header || m_prog || (m_bytes.size() != 0)));
      chk({tag, ".state"}, 32'(dbg_state_o), 32'(!m_header));
      chk({tag, ".count"}, 32'(dbg_count_o), 32'(exp_q.size()));
   endtask

   // Drive one cycle of inputs, advance model on the edge, check at negedge.
   task automatic cycle(input bit v, input logic [7:0] d, input bit rd, input bit ak);
      byte_valid          = v;
      byte_data           = d;
      program_buffer_read = rd;
      program_ack         = ak;
      @(posedge clk);
      model_edge(v, d, rd, ak);
      @(negedge clk);
      check_all("cyc");
   endtask

   // Offer a byte until accepted (bounded).
   task automatic send_byte(input logic [7:0] d, input bit rd);
      int n = 0;
      do begin
         cycle(1'b1, d, rd, auto_ack && m_prog);
         n++;
      end while (!m_acc && n < 100);
      if (!m_acc) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: byte %h not accepted within %0d cycles", d, n);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24], 1'b0);
      send_byte(w[23:16], 1'b0);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n++;
      end
   endtask

   // Asynchronous reset in the middle of a clock phase.
   task automatic async_reset(input string tag);
      @(negedge clk);
      byte_valid          = 1'b0;
      byte_data           = 8'h00;
      program_buffer_read = 1'b0;
      program_ack         = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      chk({tag, ".ready_val"}, 32'(byte_ready), 32'd1);
      chk({tag, ".q_val"}, program_buffer_q, 32'd0);
      chk({tag, ".busy_val"}, 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_all({tag, ".release"});
   endtask

   logic [31:0] w;
   logic [31:0] last_word;
   logic [7:0]  stream[$];

   initial begin
      reset_n             = 1'b0;
      byte_valid          = 1'b0;
      byte_data           = 8'h00;
      program_buffer_read = 1'b0;
      program_ack         = 1'b0;
      auto_ack            = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all("por");
      chk("por.empty_val", 32'(program_buffer_empty), 32'd1);
      chk("por.program_val", 32'(program_o), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic image: header 2, two payload words, then pop all three.
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("basic.prog_before", 32'(program_o), 32'd0);
      send_byte(8'h02, 1'b0);
      chk("basic.prog_after", 32'(program_o), 32'd1);
      chk("basic.state_data", 32'(dbg_state_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("basic.prog_acked", 32'(program_o), 32'd0);
      send_word(32'hDEADBEEF);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      chk("basic.busy_mid", 32'(busy), 32'd1);
      send_byte(8'h78, 1'b0);
      chk("basic.busy_end", 32'(busy), 32'd0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("basic.pop0", program_buffer_q, 32'h00000002);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("basic.pop1", program_buffer_q, 32'hDEADBEEF);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("basic.pop2", program_buffer_q, 32'h12345678);
      chk("basic.empty", 32'(program_buffer_empty), 32'd1);

      // Held-off ack: payload still flows while the request is pending.
      send_word(32'h00000003);
      repeat (20) idle();
      chk("ackwait.prog_held", 32'(program_o), 32'd1);
      for (int i = 0; i < 12; i++) begin
         chk("ackwait.ready", 32'(byte_ready), 32'd1);
         w[7:0] = 8'($urandom_range(0, 255));
         cycle(1'b1, w[7:0], 1'b0, 1'b0);
      end
      chk("ackwait.count", 32'(dbg_count_o), 32'd4);
      chk("ackwait.prog_still", 32'(program_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ackwait.prog_drop", 32'(program_o), 32'd0);
      drain();

      // Full FIFO: 17-word image with no reads.
      auto_ack = 1'b1;
      send_word(32'h00000010);
      for (int i = 0; i < 15; i++) send_word($urandom);
      chk("full.ready_low", 32'(byte_ready), 32'd0);
      chk("full.count", 32'(dbg_count_o), 32'd16);
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("full.refused", 32'(dbg_count_o), 32'd16);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full.ready_back", 32'(byte_ready), 32'd1);
      last_word = $urandom;
      send_word(last_word);
      chk("full.final_count", 32'(dbg_count_o), 32'd16);
      chk("full.state_header", 32'(dbg_state_o), 32'd0);
      drain();
      chk("full.last_pop", program_buffer_q, last_word);

      // Read while empty holds q.
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_read.q_hold", program_buffer_q, last_word);
      chk("empty_read.empty", 32'(program_buffer_empty), 32'd1);

      // Zero header: stays in HEADER, refuses new header bytes until ack.
      auto_ack = 1'b0;
      send_word(32'h00000000);
      chk("zero.state", 32'(dbg_state_o), 32'd0);
      chk("zero.prog", 32'(program_o), 32'd1);
      repeat (3) begin
         chk("zero.ready_low", 32'(byte_ready), 32'd0);
         cycle(1'b1, 8'h55, 1'b0, 1'b0);
         chk("zero.count", 32'(dbg_count_o), 32'd1);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("zero.prog_drop", 32'(program_o), 32'd0);
      chk("zero.ready_back", 32'(byte_ready), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("zero.pop", program_buffer_q, 32'h00000000);

      // Simultaneous push and pop at count 1.
      auto_ack = 1'b1;
      send_word(32'h00000001);
      send_byte(8'hC1, 1'b0);
      send_byte(8'hC2, 1'b0);
      send_byte(8'hC3, 1'b0);
      send_byte(8'hC4, 1'b1);
      chk("pushpop.count", 32'(dbg_count_o), 32'd1);
      chk("pushpop.q", program_buffer_q, 32'h00000001);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pushpop.pop", program_buffer_q, 32'hC1C2C3C4);

      // Reset mid-image, then a fresh header.
      send_word(32'h00000005);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      async_reset("midreset");
      send_word(32'h00000001);
      chk("midreset.new_prog", 32'(program_o), 32'd1);
      chk("midreset.new_state", 32'(dbg_state_o), 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      chk("midreset.pop", program_buffer_q, 32'h00000001);
      send_word($urandom);
      drain();

      // Randomized image streams with random reads and acks.
      for (int img = 0; img < 8; img++) begin
         int len = $urandom_range(0, 6);
         w = 32'(len);
         stream.push_back(w[31:24]);
         stream.push_back(w[23:16]);
         stream.push_back(w[15:8]);
         stream.push_back(w[7:0]);
         for (int b = 0; b < len * 4; b++) stream.push_back(8'($urandom_range(0, 255)));
      end
      for (int c = 0; c < 4000 && stream.size() > 0; c++) begin
         cycle($urandom_range(0, 3) != 0, stream[0], $urandom_range(0, 2) == 0,
               $urandom_range(0, 3) == 0);
         if (m_acc) void'(stream.pop_front());
      end
      if (stream.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL random_timeout: %0d bytes left, expected 0", stream.size());
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      drain();
      chk("final.empty", 32'(program_buffer_empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of the program-buffer depth (16 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port byte_data, input, 8, host byte stream.
REQ-005 SHALL have port byte_valid, input, 1, byte_data is valid this cycle.
REQ-006 SHALL have port byte_ready, output, 1, the block accepts byte_data this cycle.
REQ-007 SHALL have port program, output, 1, level request to the memory block to start a flash program sequence.
REQ-008 SHALL have port program_ack, input, 1, one-cycle acknowledge from the memory block.
REQ-009 SHALL have port program_buffer_empty, output, 1, the FIFO holds no words.
REQ-010 SHALL have port program_buffer_q, output, 32, registered FIFO read data.
REQ-011 SHALL have port program_buffer_read, input, 1, FIFO pop request from the memory block.
REQ-012 SHALL have port busy, output, 1, a program image is being assembled or the request is pending.

Function
REQ-013 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both 1.
REQ-014 SHALL pack accepted bytes big-endian: first byte to [31:24], fourth byte to [7:0]; a 2-bit lane counter wraps 3->0.
REQ-015 SHALL write the assembled word into the FIFO on the same edge that accepts its fourth byte.
REQ-016 SHALL drive byte_ready = (FIFO count < 2^FIFO_AW) AND NOT (state==HEADER AND program==1).
REQ-017 SHALL implement two states: HEADER (next word is a header) and DATA (collecting payload words).
REQ-018 In HEADER, the completed word is the header: it SHALL be written to the FIFO, set program to 1, and load words_remaining (32-bit) with the header value.
REQ-019 HEADER->DATA SHALL occur on the header write if the header value is nonzero; a zero header SHALL stay in HEADER, and program is still requested.
REQ-020 In DATA, each written word SHALL decrement words_remaining; DATA->HEADER SHALL occur on the write that brings it to 0.
REQ-021 program SHALL remain 1 until program_ack is sampled at 1 and SHALL be 0 on the following cycle; program_ack while program is 0 SHALL be ignored.
REQ-022 Payload bytes SHALL continue to be accepted while program is 1 and ack is outstanding.
REQ-023 The FIFO SHALL be 2^FIFO_AW x 32 with wrap-around read and write pointers and a count of width FIFO_AW+1.
REQ-024 program_buffer_read with FIFO non-empty SHALL load program_buffer_q with the head word on that edge (1-cycle latency) and pop it.
REQ-025 program_buffer_read while empty SHALL be ignored and program_buffer_q SHALL hold.
REQ-026 A simultaneous write and read SHALL leave the count unchanged; when full, a write occurs only if a read occurs on the same cycle (guaranteed by REQ-016).
REQ-027 program_buffer_empty SHALL equal (count==0), combinational from registered count.
REQ-028 busy SHALL equal (state==DATA) OR program OR (lane != 0).

Reset
REQ-029 reset_n=0 SHALL asynchronously force state=HEADER, lane=0, words_remaining=0, program=0, FIFO pointers and count=0, program_buffer_q=0.
REQ-030 Reset mid-image SHALL discard all partial words and FIFO contents; the next accepted byte after release is treated as header byte 0.

Verification
REQ-031 Send bytes 00 00 00 02, DE AD BE EF, 12 34 56 78; pop 3 words -> q = 00000002, DEADBEEF, 12345678; program rises 1 cycle after the 4th byte; busy falls after the 12th byte.
REQ-032 Header 00000003 with program_ack held 0 for 20 cycles -> program stays 1 and all 12 payload bytes are accepted; ack for 1 cycle -> program 0 on the next cycle.
REQ-033 No reads with a 17-word image -> after 16 words, byte_ready=0 and count=16; one read -> byte_ready=1 next cycle; the final word is accepted.
REQ-034 Header 00000000 -> state stays HEADER and program pulses until ack; new header bytes are refused (byte_ready=0) until ack; q=00000000 on pop.
REQ-035 Read while empty -> q unchanged and empty=1; simultaneous push/pop at count=1 -> count stays 1.
REQ-036 reset_n low after 6 bytes of an image -> all outputs at reset values immediately; next 4 bytes 00 00 00 01 are taken as a new header.
